// File: rtl/iterative_alu.sv
// iterative_alu: handshaked EX-stage ALU.
// ADD/SUB/AND/XOR/SLL/SRA (and reserved codes) finish one cycle after accept.
// MUL is a WIDTH-step shift-add unit, so there is no wide combinational multiplier.
// Optional macro ALU_DIV_EN adds signed restoring DIV/REM (WIDTH steps).
// Without the macro, codes 7/8 behave as reserved.
module iterative_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_AND = 4'd3, OP_XOR = 4'd4,
    OP_SLL = 4'd5, OP_SRA = 4'd6, OP_DIV = 4'd7, OP_REM = 4'd8
  } alu_op_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // MUL partial product / DIV partial remainder
  logic [WIDTH-1:0] opa_q, opa_d;   // MUL multiplicand / DIV divisor magnitude
  logic [WIDTH-1:0] opb_q, opb_d;   // MUL multiplier / DIV dividend-in, quotient-out
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] simple_res;
  logic [WIDTH-1:0] mul_acc;
  logic             accept;
  logic             last_step;

  assign ready_o   = (state_q == S_IDLE) || ((state_q == S_DONE) && ready_i);
  assign accept    = valid_i && ready_o && !flush_i;
  assign valid_o   = (state_q == S_DONE);
  assign busy_o    = (state_q == S_BUSY);
  assign data_o    = data_q;
  assign Zero_o    = (data_q == '0);
  assign last_step = (cnt_q == SHW'(WIDTH - 1));
  assign mul_acc   = acc_q + (opb_q[0] ? opa_q : '0);

`ifdef ALU_DIV_EN
  logic             is_div_q, is_div_d;
  logic             is_rem_q, is_rem_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH:0]   div_sh, div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem, div_quo;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  // One restoring step: shift next dividend bit in, subtract divisor if it fits.
  assign div_sh    = {acc_q, opb_q[WIDTH-1]};
  assign div_trial = div_sh - {1'b0, opa_q};
  assign div_ok    = !div_trial[WIDTH];
  assign div_rem   = div_ok ? div_trial[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_quo   = {opb_q[WIDTH-2:0], div_ok};
`endif

  // Result of the single-cycle ops, straight from the request operands.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    simple_res = '0;
    case (ALUCtrl_i)
      OP_ADD:  simple_res = data1_i + data2_i;
      OP_SUB:  simple_res = data1_i - data2_i;
      OP_AND:  simple_res = data1_i & data2_i;
      OP_XOR:  simple_res = data1_i ^ data2_i;
      OP_SLL:  simple_res = data1_i << data2_i[SHW-1:0];
      OP_SRA:  simple_res = WIDTH'($signed(data1_i) >>> data2_i[SHW-1:0]);
      default: simple_res = '0;
    endcase
  end

  // Next-state: flush, iteration step, accept of a new request, or drain.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
`ifdef ALU_DIV_EN
    is_div_d = is_div_q;
    is_rem_d = is_rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
`endif
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_BUSY) begin
      cnt_d = cnt_q + SHW'(1);
`ifdef ALU_DIV_EN
      if (is_div_q) begin
        acc_d = div_rem;
        opb_d = div_quo;
        if (last_step) begin
          state_d = S_DONE;
          data_d  = is_rem_q ? (negr_q ? -div_rem : div_rem)
                             : (negq_q ? -div_quo : div_quo);
        end
      end else
`endif
      begin
        acc_d = mul_acc;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        if (last_step) begin
          state_d = S_DONE;
          data_d  = mul_acc;
        end
      end
    end else if (accept) begin
      cnt_d = '0;
      acc_d = '0;
      case (ALUCtrl_i)
        OP_MUL: begin
          state_d = S_BUSY;
          opa_d   = data1_i;
          opb_d   = data2_i;
`ifdef ALU_DIV_EN
          is_div_d = 1'b0;
`endif
        end
`ifdef ALU_DIV_EN
        OP_DIV, OP_REM: begin
          is_rem_d = (ALUCtrl_i == OP_REM);
          if (data2_i == '0) begin
            // Divide by zero resolves immediately without iterating.
            state_d = S_DONE;
            data_d  = (ALUCtrl_i == OP_REM) ? data1_i : '1;
          end else begin
            state_d  = S_BUSY;
            is_div_d = 1'b1;
            opa_d    = mag(data2_i);
            opb_d    = mag(data1_i);
            negq_d   = data1_i[WIDTH-1] ^ data2_i[WIDTH-1];
            negr_d   = data1_i[WIDTH-1];
          end
        end
`endif
        default: begin
          state_d = S_DONE;
          data_d  = simple_res;
        end
      endcase
    end else if ((state_q == S_DONE) && ready_i) begin
      state_d = S_IDLE;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_i) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
`ifdef ALU_DIV_EN
      is_div_q <= 1'b0;
      is_rem_q <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
`ifdef ALU_DIV_EN
      is_div_q <= is_div_d;
      is_rem_q <= is_rem_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
`endif
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: directed scoreboard bench for iterative_alu (WIDTH=32).
// Expected results come from a behavioural reference model and are queued
// when a request is driven, then popped when the DUT presents valid_o.
module tb_iterative_alu;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i, flush_i, valid_i, ready_o, ready_i;
  logic         valid_o, Zero_o, busy_o;
  logic [3:0]   ALUCtrl_i;
  logic [W-1:0] data1_i, data2_i, data_o;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  int           busy_cnt, rdy_seen;

  iterative_alu #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .ALUCtrl_i(ALUCtrl_i), .data1_i(data1_i), .data2_i(data2_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .Zero_o(Zero_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference ALU written with the native operators.
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb, sr;
    sa = a;
    sb = b;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a * b;
      4'd3: return a & b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: begin sr = sa >>> b[4:0]; return sr; end
`ifdef ALU_DIV_EN
      4'd7: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == '1) return 32'h8000_0000;
        sr = sa / sb;
        return sr;
      end
      4'd8: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == '1) return '0;
        sr = sa % sb;
        return sr;
      end
`endif
      default: return '0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one request, wait for ready_o (bounded), queue its expected result.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!ready_o && n < 100) begin step(); n++; end
    check("send_ready", 32'(ready_o), 32'd1);
    ALUCtrl_i = op; data1_i = a; data2_i = b; valid_i = 1'b1;
    exp_q.push_back(model(op, a, b));
    step();
    valid_i = 1'b0;
    // Scramble operands: the unit must have latched them already.
    data1_i = $urandom; data2_i = $urandom; ALUCtrl_i = 4'($urandom_range(0, 15));
  endtask

  // Wait (bounded) for valid_o; latency counts the accept edge as 1.
  task automatic await(input string tag, input int exp_lat);
    int lat = 1;
    busy_cnt = 0;
    rdy_seen = 0;
    while (!valid_o && lat < 100) begin
      if (busy_o) busy_cnt++;
      if (ready_o) rdy_seen++;
      step();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      last_exp = 'x;
    end else begin
      last_exp = exp_q.pop_front();
      check({tag, "_data"}, data_o, last_exp);
      check({tag, "_zero"}, 32'(Zero_o), 32'(last_exp == 0));
    end
  endtask

  task automatic consume(input string tag);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    check({tag, "_drain"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    int bad;
    rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b1; ready_i = 1'b0;
    ALUCtrl_i = 4'd0; data1_i = 32'd1; data2_i = 32'd1;

    // Reset held two edges with a request pending.
    step(); step();
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst_i = 1'b1; valid_i = 1'b0;
    check("rst_ready", 32'(ready_o), 32'd1);

    // Single-cycle ops, wrap and shift boundaries.
    send(4'd0, 32'hFFFF_FFFF, 32'd1);  await("add_wrap", 1); consume("add_wrap");
    send(4'd6, 32'h8000_0000, 32'h21); await("sra", 1);      consume("sra");
    send(4'd1, 32'd3, 32'd5);          await("sub", 1);      consume("sub");
    send(4'd5, 32'h0000_00F1, 32'h24); await("sll", 1);      consume("sll");
    send(4'd12, 32'h1234, 32'h5678);   await("rsvd", 1);     consume("rsvd");

    // Iterative multiply: latency, busy span, no ready while iterating.
    send(4'd2, 32'h0001_0003, 32'hFFFF_FFFE); await("mul", 33);
    check("mul_busy_cycles", 32'(busy_cnt), 32'd32);
    check("mul_ready_low", 32'(rdy_seen), 32'd0);
    consume("mul");

    // Back-pressure then back-to-back accept on the consume edge.
    send(4'd3, 32'hFF00_FF00, 32'h0FF0_0FF0); await("and", 1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (data_o !== last_exp || ready_o !== 1'b0 || valid_o !== 1'b1) bad++;
    end
    check("hold_violations", 32'(bad), 32'd0);
    ALUCtrl_i = 4'd4; data1_i = 32'hF0F0; data2_i = 32'h0FF0; valid_i = 1'b1; ready_i = 1'b1;
    exp_q.push_back(model(4'd4, 32'hF0F0, 32'h0FF0));
    step();
    valid_i = 1'b0; ready_i = 1'b0;
    await("b2b_xor", 1); consume("b2b_xor");

    // Flush at BUSY step 10 of a multiply: result discarded.
    ALUCtrl_i = 4'd2; data1_i = 32'd5; data2_i = 32'd7; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    for (int i = 0; i < 10; i++) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_busy", 32'(busy_o), 32'd0);
    check("flush_ready", 32'(ready_o), 32'd1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) bad++;
      step();
    end
    check("flush_no_valid", 32'(bad), 32'd0);

    // Request coinciding with flush in IDLE is not accepted.
    ALUCtrl_i = 4'd0; data1_i = 32'd1; data2_i = 32'd1; valid_i = 1'b1; flush_i = 1'b1;
    step();
    valid_i = 1'b0; flush_i = 1'b0;
    check("flush_mask_valid", 32'(valid_o), 32'd0);
    check("flush_mask_busy", 32'(busy_o), 32'd0);

    send(4'd0, 32'd2, 32'd3); await("post_flush_add", 1); consume("post_flush_add");

`ifdef ALU_DIV_EN
    send(4'd7, 32'hFFFF_FFF9, 32'd2);         await("div_neg", 33);   consume("div_neg");
    send(4'd8, 32'hFFFF_FFF9, 32'd2);         await("rem_neg", 33);   consume("rem_neg");
    send(4'd7, 32'd100, 32'hFFFF_FFF9);       await("div_pos_neg", 33); consume("div_pos_neg");
    send(4'd7, 32'h1234_5678, 32'd0);         await("div_zero", 1);   consume("div_zero");
    send(4'd8, 32'h1234_5678, 32'd0);         await("rem_zero", 1);   consume("rem_zero");
    send(4'd7, 32'h8000_0000, 32'hFFFF_FFFF); await("div_ovf", 33);   consume("div_ovf");
    send(4'd8, 32'h8000_0000, 32'hFFFF_FFFF); await("rem_ovf", 33);   consume("rem_ovf");
`else
    send(4'd7, 32'd100, 32'd7); await("div_rsvd", 1); consume("div_rsvd");
    send(4'd8, 32'd100, 32'd7); await("rem_rsvd", 1); consume("rem_rsvd");
`endif

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Parametrised, handshaked successor to the EX-stage single-cycle ALU.
- Logic and add/shift ops complete in 1 cycle. MUL runs as a WIDTH-step shift-add iterative unit, so no wide combinational multiplier is needed.
- Sits in EX. The hazard unit stalls IF/ID/EX while ready_o or valid_o hold the pipe.
- flush_i aborts in-flight work on a branch flush.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, >=8).
- SHW, $clog2(WIDTH), shift-amount bits taken from data2_i[SHW-1:0].

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-low (rst_i==0 at posedge resets).
- flush_i  in  1  abort current op; discard result.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request this cycle.
- ALUCtrl_i  in  4  op: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 XOR, 5 SLL, 6 SRA, 7 DIV, 8 REM; 9-15 reserved.
- data1_i  in  WIDTH  operand A.
- data2_i  in  WIDTH  operand B.
- valid_o  out  1  result valid; held until consumed.
- ready_i  in  1  consumer accepts result.
- data_o  out  WIDTH  registered result.
- Zero_o  out  1  data_o==0, valid only with valid_o.
- busy_o  out  1  FSM in BUSY (iterating).

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (rst_i==0 at posedge): state=IDLE, valid_o=0, data_o=0, busy_o=0, step counter=0, internal accumulators=0.
- Ready: ready_o = (state==IDLE) || (state==DONE && ready_i). Registered state only; no combinational path from valid_i.
- Accept: valid_i && ready_o at posedge. Operands and op are latched; later input changes are ignored.
- Single-cycle ops (ADD, SUB, AND, XOR, SLL, SRA, reserved):
  - Accept edge N: go to DONE; data_o and valid_o=1 visible after edge N.
  - Latency 1 cycle.
- ADD/SUB wrap modulo 2^WIDTH.
- SLL/SRA use only B[SHW-1:0]; SRA is arithmetic.
- Reserved codes give data_o=0.
- MUL:
  - Accept edge: go to BUSY, counter=0.
  - Each BUSY cycle: if multiplier LSB set, acc+=multiplicand; multiplicand<<=1; multiplier>>=1; counter++.
  - After WIDTH steps, go to DONE.
  - valid_o rises WIDTH+1 edges after accept. Result is the low WIDTH bits (unsigned and signed products agree).
- DONE:
  - valid_o=1, data_o stable.
  - ready_i=1: result consumed at that edge. Same edge may accept a new request (back-to-back, no bubble). Otherwise go to IDLE, valid_o=0.
  - ready_i=0: hold indefinitely.
- flush_i:
  - Highest priority below reset. Any state goes to IDLE, valid_o=0, counter=0.
  - A request presented with flush_i is not accepted (ready_o is still reported, but accept is masked).
- Reset mid-BUSY: same as reset; partial product discarded.
- Zero_o = (data_o==0), evaluated on the registered result.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined:
  - DIV/REM use signed restoring division: magnitudes, WIDTH BUSY steps, sign fix-up in the final step. Latency WIDTH+1, same as MUL.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by 0: DIV gives all-ones, REM gives the dividend. Takes 1 cycle (no BUSY).
  - MIN/-1: DIV gives MIN, REM gives 0.
- Undefined: codes 7 and 8 are treated as reserved (1 cycle, data_o=0). No divider logic is synthesised.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with valid_i=1 -> valid_o=0, data_o=0, busy_o=0, ready_o=1 after release.
- Single-cycle ops:
  - ADD 0xFFFFFFFF+1 -> data_o=0, Zero_o=1, valid_o 1 cycle after accept.
  - SRA 0x80000000 by B=0x21 (uses 1) -> 0xC0000000.
- MUL: 0x0001_0003 * 0xFFFF_FFFE -> 0xFFFD_FFFA. valid_o rises exactly 33 edges after accept; busy_o=1 for 32 cycles; ready_o=0 throughout.
- Back-pressure and back-to-back:
  - Hold ready_i=0 for 5 cycles in DONE -> data_o stable, ready_o=0.
  - Then ready_i=1 with valid_i=1 (XOR 0xF0F0^0x0FF0) -> old result consumed and new one accepted on the same edge; next valid_o shows 0xFF00.
- Flush: assert flush_i at BUSY step 10 of a MUL -> IDLE next edge, valid_o never rises, the next ADD 2+3 returns 5 in 1 cycle.
- ALU_DIV_EN:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIV x/0 -> 0xFFFFFFFF in 1 cycle.
  - 0x80000000 / -1 -> 0x80000000.
  - With the macro undefined, DIV returns 0 in 1 cycle.
